// File: rtl/regfile_scan_ctrl_if.sv
// rtl/regfile_scan_ctrl_if.sv - control, register-file port and result signals of the min/max scan controller
interface regfile_scan_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic                     Start;
    logic                     Busy;
    logic                     Done;
    logic [ADDR_W-1:0]        R_Addr;
    logic                     R_en;
    logic [DATA_W-1:0]        R_Data;
    logic [ADDR_W-1:0]        W_Addr;
    logic                     W_en;
    logic [DATA_W-1:0]        W_Data;
    logic [DATA_W-1:0]        Min_Out;
    logic [DATA_W-1:0]        Max_Out;
    logic [ADDR_W-1:0]        Min_Idx;
    logic [ADDR_W-1:0]        Max_Idx;
    logic [DATA_W+ADDR_W-1:0] Sum_Out;

    modport master (
        input  Start, R_Data,
        output Busy, Done, R_Addr, R_en, W_Addr, W_en, W_Data,
               Min_Out, Max_Out, Min_Idx, Max_Idx, Sum_Out
    );

    modport slave (
        output Start, R_Data,
        input  Busy, Done, R_Addr, R_en, W_Addr, W_en, W_Data,
               Min_Out, Max_Out, Min_Idx, Max_Idx, Sum_Out
    );
endinterface

// File: rtl/regfile_scan_ctrl.sv
// rtl/regfile_scan_ctrl.sv - scans the register file for min/max/sum and optionally writes min/max back
module regfile_scan_ctrl #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 4,
    parameter int                 DEPTH    = 16,
    parameter int                 WB_EN    = 1,
    parameter logic [ADDR_W-1:0]  MIN_ADDR = ADDR_W'(0),
    parameter logic [ADDR_W-1:0]  MAX_ADDR = ADDR_W'(15)
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    regfile_scan_ctrl_if.master   bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_WR_MIN = 3'd2;
    localparam logic [2:0] S_WR_MAX = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        AFTER_SCAN = (WB_EN != 0) ? S_WR_MIN : S_DONE;
    localparam int                SUM_W      = DATA_W + ADDR_W;

    logic [2:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] min_q;
    logic [DATA_W-1:0] max_q;
    logic [ADDR_W-1:0] min_idx_q;
    logic [ADDR_W-1:0] max_idx_q;
    logic [SUM_W-1:0]  sum_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            sum_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.Start) begin
                        state <= S_SCAN;
                        idx   <= '0;
                    end
                end
                S_SCAN: begin
                    // Read data is combinational, so it is consumed at the same edge it is addressed.
                    if (idx == '0) begin
                        min_q     <= bus.R_Data;
                        max_q     <= bus.R_Data;
                        min_idx_q <= '0;
                        max_idx_q <= '0;
                        sum_q     <= SUM_W'(bus.R_Data);
                    end else begin
                        if (bus.R_Data < min_q) begin
                            min_q     <= bus.R_Data;
                            min_idx_q <= idx;
                        end
                        if (bus.R_Data > max_q) begin
                            max_q     <= bus.R_Data;
                            max_idx_q <= idx;
                        end
                        sum_q <= sum_q + SUM_W'(bus.R_Data);
                    end
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= AFTER_SCAN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_WR_MIN: state <= S_WR_MAX;
                S_WR_MAX: state <= S_DONE;
                S_DONE:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Port strobes decode straight from state so an async reset clears them without waiting for an edge.
    assign bus.Busy    = (state != S_IDLE);
    assign bus.Done    = (state == S_DONE);
    assign bus.R_en    = (state == S_SCAN);
    assign bus.R_Addr  = (state == S_SCAN) ? idx : '0;
    assign bus.W_en    = (state == S_WR_MIN) || (state == S_WR_MAX);
    assign bus.W_Addr  = (state == S_WR_MIN) ? MIN_ADDR :
                         (state == S_WR_MAX) ? MAX_ADDR : '0;
    assign bus.W_Data  = (state == S_WR_MIN) ? min_q :
                         (state == S_WR_MAX) ? max_q : '0;
    assign bus.Min_Out = min_q;
    assign bus.Max_Out = max_q;
    assign bus.Min_Idx = min_idx_q;
    assign bus.Max_Idx = max_idx_q;
    assign bus.Sum_Out = sum_q;
endmodule
